// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit with tag, flush and exception reporting.
// Define MULTDIV_REM_EN to add the remainder output.
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic [TAG_W-1:0] tag_out
`ifdef MULTDIV_REM_EN
    ,
    output logic [WIDTH-1:0] remainder
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               fix_q, fix_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               div_q, div_d;
    logic               neg_q, neg_d;
    logic               sgna_q, sgna_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               exc_q, exc_d;
    logic [TAG_W-1:0]   tago_q, tago_d;
`ifdef MULTDIV_REM_EN
    logic [WIDTH-1:0]   rem_q, rem_d;
`endif

    logic [WIDTH-1:0] a_mag, b_mag;
    logic             accept;
    logic [WIDTH:0]   msum, shrem, trial;
    logic [WIDTH-1:0] quot, prem;
    logic [WIDTH:0]   phi;

    assign a_mag = operand_a[WIDTH-1] ? -operand_a : operand_a;
    assign b_mag = operand_b[WIDTH-1] ? -operand_b : operand_b;

    assign accept = (state_q == IDLE || state_q == DONE)
                  && (start_mult || start_div) && !flush;

    // Multiply step: add multiplicand into upper half, shift right.
    assign msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + (acc_q[0] ? {1'b0, opb_q} : '0);

    // Restoring divide step on {partial remainder, dividend/quotient}.
    assign shrem = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign trial = shrem - {1'b0, opb_q};

    assign quot = acc_q[WIDTH-1:0];
    assign prem = acc_q[2*WIDTH-1:WIDTH];
    assign phi  = acc_q[2*WIDTH-1:WIDTH-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fix_d   = fix_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        div_d   = div_q;
        neg_d   = neg_q;
        sgna_d  = sgna_q;
        tag_d   = tag_q;
        res_d   = res_q;
        exc_d   = exc_q;
        tago_d  = tago_q;
`ifdef MULTDIV_REM_EN
        rem_d   = rem_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    tag_d  = tag_in;
                    div_d  = !start_mult;
                    neg_d  = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                    sgna_d = operand_a[WIDTH-1];
                    cnt_d  = '0;
                    fix_d  = 1'b0;
                    state_d = RUN;
                    if (start_mult) begin
                        opb_d = a_mag;
                        acc_d = {{WIDTH{1'b0}}, b_mag};
                    end else begin
                        opb_d = b_mag;
                        acc_d = {{WIDTH{1'b0}}, a_mag};
                    end
                    // Divide by zero bypasses the iteration entirely.
                    if (!start_mult && operand_b == '0) begin
                        state_d = DONE;
                        res_d   = '0;
                        exc_d   = 1'b1;
                        tago_d  = tag_in;
`ifdef MULTDIV_REM_EN
                        rem_d   = operand_a;
`endif
                    end
                end
            end
            RUN: begin
                if (div_q) begin
                    acc_d = {trial[WIDTH] ? shrem[WIDTH-1:0] : trial[WIDTH-1:0],
                             acc_q[WIDTH-2:0], ~trial[WIDTH]};
                end else begin
                    acc_d = {msum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (!fix_q) begin
                    fix_d = 1'b1;
                    if (div_q) begin
                        acc_d = {sgna_q ? -prem : prem, neg_q ? -quot : quot};
                    end else begin
                        acc_d = neg_q ? -acc_q : acc_q;
                    end
                end else if (!flush) begin
                    state_d = DONE;
                    res_d   = quot;
                    tago_d  = tag_q;
                    if (div_q) begin
                        // Only MIN / -1 yields a positive quotient with MSB set.
                        exc_d = !neg_q && quot[WIDTH-1];
                    end else begin
                        exc_d = !((&phi) || !(|phi));
                    end
`ifdef MULTDIV_REM_EN
                    rem_d = div_q ? prem : '0;
`endif
                end
            end
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fix_q   <= 1'b0;
            acc_q   <= '0;
            opb_q   <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            sgna_q  <= 1'b0;
            tag_q   <= '0;
            res_q   <= '0;
            exc_q   <= 1'b0;
            tago_q  <= '0;
`ifdef MULTDIV_REM_EN
            rem_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fix_q   <= fix_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            sgna_q  <= sgna_d;
            tag_q   <= tag_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
            tago_q  <= tago_d;
`ifdef MULTDIV_REM_EN
            rem_q   <= rem_d;
`endif
        end
    end

    assign busy         = (state_q == RUN) || (state_q == FIX);
    assign result_valid = (state_q == DONE);
    assign result       = res_q;
    assign exception    = exc_q;
    assign tag_out      = tago_q;
`ifdef MULTDIV_REM_EN
    assign remainder    = rem_q;
`endif

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit at WIDTH=32.
// Remainder checks are active when MULTDIV_REM_EN is defined.
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_mult = 1'b0;
    logic        start_div = 1'b0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic [4:0]  tag_in = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;
    logic        exception;
    logic [4:0]  tag_out;
`ifdef MULTDIV_REM_EN
    logic [31:0] remainder;
`endif

    int n_pass = 0;
    int n_chk  = 0;

    multdiv_unit #(.WIDTH(32), .TAG_W(5)) dut (
        .clock(clock),
        .reset(reset),
        .start_mult(start_mult),
        .start_div(start_div),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .tag_in(tag_in),
        .flush(flush),
        .busy(busy),
        .result_valid(result_valid),
        .result(result),
        .exception(exception),
        .tag_out(tag_out)
`ifdef MULTDIV_REM_EN
        ,
        .remainder(remainder)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // n = clock edges after the start edge until result_valid is seen.
    task automatic wait_valid(output int n, output int bc);
        n = 0;
        bc = 0;
        while (!result_valid && n < 100) begin
            if (busy) bc++;
            tick();
            n++;
        end
    endtask

    task automatic do_op(input string nm, input logic op_div,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tg, input logic [31:0] eres,
                         input logic eexc, input logic [31:0] erem,
                         input int elat);
        int n, bc;
        operand_a  = a;
        operand_b  = b;
        tag_in     = tg;
        start_div  = op_div;
        start_mult = !op_div;
        tick();
        start_mult = 1'b0;
        start_div  = 1'b0;
        wait_valid(n, bc);
        chk({nm, ".lat"}, 64'(n), 64'(elat));
        chk({nm, ".busycyc"}, 64'(bc), 64'(elat));
        chk({nm, ".busy_at_valid"}, 64'(busy), 64'd0);
        chk({nm, ".res"}, 64'(result), 64'(eres));
        chk({nm, ".exc"}, 64'(exception), 64'(eexc));
        chk({nm, ".tag"}, 64'(tag_out), 64'(tg));
`ifdef MULTDIV_REM_EN
        chk({nm, ".rem"}, 64'(remainder), 64'(erem));
`else
        if (erem === 32'hxxxxxxxx) chk({nm, ".remarg"}, 64'(erem), 64'd0);
`endif
    endtask

    initial begin
        int n, bc, pulses;

        tick();
        tick();
        reset = 1'b0;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.valid", 64'(result_valid), 64'd0);
        chk("rst.res", 64'(result), 64'd0);
        chk("rst.exc", 64'(exception), 64'd0);
        chk("rst.tag", 64'(tag_out), 64'd0);

        do_op("mul_m7x6", 1'b0, -32'sd7, 32'sd6, 5'd9, 32'hFFFFFFD6, 1'b0, 32'd0, 34);
        tick();
        chk("hold.valid", 64'(result_valid), 64'd0);
        chk("hold.res", 64'(result), 64'hFFFFFFD6);
        chk("hold.tag", 64'(tag_out), 64'd9);

        do_op("div_m100_7", 1'b1, -32'sd100, 32'sd7, 5'd3, 32'hFFFFFFF2, 1'b0, 32'hFFFFFFFE, 34);
        // Back-to-back: next starts are issued in the DONE cycle.
        do_op("div_by0", 1'b1, 32'd5, 32'd0, 5'd4, 32'd0, 1'b1, 32'd5, 0);
        do_op("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd5, 32'h80000000, 1'b1, 32'd0, 34);
        do_op("div_7_m2", 1'b1, 32'd7, -32'sd2, 5'd6, 32'hFFFFFFFD, 1'b0, 32'd1, 34);
        do_op("div_min_1", 1'b1, 32'h80000000, 32'd1, 5'd7, 32'h80000000, 1'b0, 32'd0, 34);
        do_op("mul_min_m1", 1'b0, 32'h80000000, 32'hFFFFFFFF, 5'd8, 32'h80000000, 1'b1, 32'd0, 34);
        do_op("mul_min_1", 1'b0, 32'h80000000, 32'd1, 5'd10, 32'h80000000, 1'b0, 32'd0, 34);
        do_op("mul_m1_m1", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, 32'd1, 1'b0, 32'd0, 34);

        // Overflowing multiply with a second start issued while busy.
        operand_a = 32'h10000;
        operand_b = 32'h10000;
        tag_in = 5'd12;
        start_mult = 1'b1;
        tick();
        start_mult = 1'b0;
        tick();
        tick();
        operand_a = 32'd2;
        operand_b = 32'd3;
        tag_in = 5'd13;
        start_mult = 1'b1;
        tick();
        start_mult = 1'b0;
        wait_valid(n, bc);
        chk("ign.lat", 64'(n), 64'd31);
        chk("ign.res", 64'(result), 64'd0);
        chk("ign.exc", 64'(exception), 64'd1);
        chk("ign.tag", 64'(tag_out), 64'd12);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (result_valid) pulses++;
        end
        chk("ign.pulses", 64'(pulses), 64'd0);

        // Flush at cycle 10 of a divide.
        operand_a = 32'd1000;
        operand_b = 32'd3;
        tag_in = 5'd14;
        start_div = 1'b1;
        tick();
        start_div = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush.busy", 64'(busy), 64'd0);
        chk("flush.valid", 64'(result_valid), 64'd0);
        chk("flush.tag", 64'(tag_out), 64'd12);
        do_op("after_flush", 1'b1, 32'd1000, 32'd3, 5'd15, 32'd333, 1'b0, 32'd1, 34);

        // Flush together with a start drops the start.
        operand_a = 32'd4;
        operand_b = 32'd4;
        start_mult = 1'b1;
        flush = 1'b1;
        tick();
        start_mult = 1'b0;
        flush = 1'b0;
        chk("flush_start.busy", 64'(busy), 64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (result_valid || busy) pulses++;
        end
        chk("flush_start.idle", 64'(pulses), 64'd0);

        // Reset at cycle 5 of a multiply.
        operand_a = 32'd3;
        operand_b = 32'd4;
        tag_in = 5'd16;
        start_mult = 1'b1;
        tick();
        start_mult = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst.busy", 64'(busy), 64'd0);
        chk("midrst.valid", 64'(result_valid), 64'd0);
        chk("midrst.res", 64'(result), 64'd0);
        chk("midrst.tag", 64'(tag_out), 64'd0);
        do_op("after_rst", 1'b0, 32'd3, 32'd4, 5'd17, 32'd12, 1'b0, 32'd0, 34);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
